instr_encode_writer: RTL

- Write-side counterpart of the instruction decode path.
- Accepts instruction fields (opcode/rs/rt/rd/shamt/funct, imm16 or target26) over a valid/ready stream and packs them into 32-bit MIPS words.
- Writes the words to consecutive word addresses of instruction memory through a registered write port with backpressure.
- Used to load programs before or between runs of the datapath.

---
 rtl/instr_encode_writer.sv | 119 +++++++++++
 1 files changed

// File: rtl/instr_encode_writer.sv
// Packs R/I/J instruction fields into 32-bit MIPS words and streams them to
// consecutive instruction-memory addresses; one-cycle write latency, stalls on mem_ready.
module instr_encode_writer #(
    parameter int MAX_WORDS = 256,
    parameter int COUNT_W   = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        start_addr,
    input  logic               finish,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         format,
    input  logic [5:0]         opcode,
    input  logic [4:0]         rs,
    input  logic [4:0]         rt,
    input  logic [4:0]         rd,
    input  logic [4:0]         shamt,
    input  logic [5:0]         funct,
    input  logic [15:0]        imm16,
    input  logic [25:0]        target26,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_ready,
    output logic [COUNT_W-1:0] word_count,
    output logic               done,
    output logic               misaligned,
    output logic               bad_format
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_WORDS);
    localparam logic [COUNT_W-1:0] ONE     = COUNT_W'(1);

    state_t      state;
    logic [31:0] next_addr;
    logic [31:0] encoded;
    logic        wr_free;
    logic        at_cap;
    logic        accept;
    logic        legal;

    // The write slot is free when empty or when its current word leaves this edge.
    assign wr_free  = !mem_we || mem_ready;
    assign at_cap   = (word_count >= MAX_CNT);
    assign in_ready = (state == S_RUN) && wr_free && !at_cap;
    assign accept   = in_valid && in_ready;
    assign legal    = (format != 2'd3);

    always_comb begin
        encoded = '0;
        case (format)
            2'd0:    encoded = {opcode, rs, rt, rd, shamt, funct};
            2'd1:    encoded = {opcode, rs, rt, imm16};
            2'd2:    encoded = {opcode, target26};
            default: encoded = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            bad_format <= 1'b0;
            next_addr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        next_addr  <= {start_addr[31:2], 2'b00};
                        misaligned <= |start_addr[1:0];
                        word_count <= '0;
                        done       <= 1'b0;
                        bad_format <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (mem_we && mem_ready)
                        mem_we <= 1'b0;
                    if (accept) begin
                        if (legal) begin
                            mem_we     <= 1'b1;
                            mem_addr   <= next_addr;
                            mem_wdata  <= encoded;
                            next_addr  <= next_addr + 32'd4;
                            word_count <= word_count + ONE;
                        end else begin
                            bad_format <= 1'b1;
                        end
                    end
                    if (finish || (accept && legal && (word_count == MAX_CNT - ONE)))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (wr_free) begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
